// File: rtl/clk_div_gen_pkg.sv
// rtl/clk_div_gen_pkg.sv - shared types and constants for the multi-channel clock divider
package clk_div_gen_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int DIV_STOP  = 0;

    typedef logic [DIV_W_DEF-1:0] div_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/clk_div_gen_chan.sv
// rtl/clk_div_gen_chan.sv - one divider channel: run FSM, phase counter, divisor update handshake
module clk_div_gen_chan
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             active_o
);

    localparam logic [DIV_W-1:0] LP_STOP = DIV_W'(DIV_STOP);
    localparam logic [DIV_W-1:0] LP_ONE  = DIV_W'(1);

    chan_state_e      r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_apply_nxt;
    logic             r_stop;
    logic             r_clk;
    logic             r_rise;
    logic             r_fall;

    logic             w_xfer;
    logic             w_tc;
    logic             w_start;
    logic [DIV_W-1:0] w_idle_div;
    logic [DIV_W-1:0] w_next_div;

    assign w_xfer     = cfg_valid_i && !r_pend;
    assign w_tc       = (r_cnt == r_div_q - LP_ONE);
    assign w_next_div = r_pend ? r_div_pend : r_div_q;

    // A divisor arriving in the same idle cycle as the run request wins.
    always_comb begin
        w_idle_div = r_div_q;
        if (w_xfer) begin
            w_idle_div = cfg_div_i;
        end else if (r_pend) begin
            w_idle_div = r_div_pend;
        end
    end

    assign w_start = en_i && (w_idle_div != LP_STOP);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_div_q     <= DIV_W'(DEFAULT_DIV);
            r_div_pend  <= '0;
            r_pend      <= 1'b0;
            r_apply_nxt <= 1'b0;
            r_stop      <= 1'b0;
            r_clk       <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_apply_nxt <= 1'b0;
            if (w_xfer) begin
                r_div_pend <= cfg_div_i;
                r_pend     <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_clk  <= 1'b0;
                    r_cnt  <= '0;
                    r_stop <= 1'b0;
                    if (r_pend) begin
                        r_div_q <= r_div_pend;
                        r_pend  <= 1'b0;
                    end
                    if (w_start) begin
                        r_state     <= RUN;
                        r_div_q     <= w_idle_div;
                        r_apply_nxt <= w_xfer;
                    end
                end
                RUN: begin
                    // Update captured on the starting edge is retired one cycle later.
                    if (r_apply_nxt) begin
                        r_div_q <= r_div_pend;
                        r_pend  <= 1'b0;
                    end
                    if (!r_clk) begin
                        if (!en_i) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (w_tc) begin
                            r_clk  <= 1'b1;
                            r_rise <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + LP_ONE;
                        end
                    end else if (w_tc) begin
                        r_clk  <= 1'b0;
                        r_fall <= 1'b1;
                        r_cnt  <= '0;
                        r_stop <= 1'b0;
                        if (r_pend) begin
                            r_div_q <= r_div_pend;
                            r_pend  <= 1'b0;
                        end
                        if (r_stop || !en_i || (w_next_div == LP_STOP)) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                        if (!en_i) begin
                            r_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_clk   <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cfg_ready_o = ~r_pend;
    assign clk_o       = r_clk;
    assign rise_o      = r_rise;
    assign fall_o      = r_fall;
    assign active_o    = (r_state == RUN);

endmodule

// File: rtl/clk_div_gen_multi.sv
// rtl/clk_div_gen_multi.sv - N independent programmable clock divider channels
module clk_div_gen_multi
    import clk_div_gen_pkg::*;
#(
    parameter int N_CHAN      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_CHAN-1:0]             en_i,
    input  logic [N_CHAN-1:0]             cfg_valid_i,
    input  logic [N_CHAN-1:0][DIV_W-1:0]  cfg_div_i,
    output logic [N_CHAN-1:0]             cfg_ready_o,
    output logic [N_CHAN-1:0]             clk_o,
    output logic [N_CHAN-1:0]             rise_o,
    output logic [N_CHAN-1:0]             fall_o,
    output logic [N_CHAN-1:0]             active_o
);

    for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
        clk_div_gen_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (en_i[g]),
            .cfg_valid_i (cfg_valid_i[g]),
            .cfg_div_i   (cfg_div_i[g]),
            .cfg_ready_o (cfg_ready_o[g]),
            .clk_o       (clk_o[g]),
            .rise_o      (rise_o[g]),
            .fall_o      (fall_o[g]),
            .active_o    (active_o[g])
        );
    end

endmodule
